// File: rtl/operar_vetores_pkg.sv
// operar_vetores_pkg: shared mode/state types and mode validity helper
package operar_vetores_pkg;
  typedef enum logic [2:0] {
    MODO_OR        = 3'd0,
    MODO_AND       = 3'd1,
    MODO_XOR       = 3'd2,
    MODO_NOT       = 3'd3,
    MODO_OR_LOGICO = 3'd4,
    MODO_ACC_OR    = 3'd5
  } modo_t;
  typedef enum logic [1:0] {
    OCIOSO     = 2'd0,
    ACUMULANDO = 2'd1,
    SAIDA      = 2'd2
  } estado_t;
  function automatic logic modo_valido(input logic [2:0] m);
    return m <= 3'd5;
  endfunction
endpackage

// File: rtl/operar_vetores_nucleo.sv
// operar_vetores_nucleo: combinational per-beat vector operator
module operar_vetores_nucleo import operar_vetores_pkg::*; #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [2:0]         modo,
  output logic [2*WIDTH-1:0] res,
  output logic               erro
);
  // single-beat result; ACC_OR yields a|b so a one-beat burst reuses this path
  always_comb begin
    erro = !modo_valido(modo);
    res = modo == MODO_NOT ? {~b, ~a}
        : modo == MODO_OR_LOGICO ? {{(2*WIDTH-1){1'b0}}, |{a, b}}
        : modo == MODO_AND ? {{WIDTH{1'b0}}, a & b}
        : modo == MODO_XOR ? {{WIDTH{1'b0}}, a ^ b}
        : (modo == MODO_OR || modo == MODO_ACC_OR) ? {{WIDTH{1'b0}}, a | b}
        : '0;
  end
endmodule

// File: rtl/operar_vetores_param.sv
// operar_vetores_param: registered vector-operation unit with valid/ready handshakes and OR accumulation
module operar_vetores_param import operar_vetores_pkg::*; #(
  parameter int WIDTH     = 8,
  parameter int MAX_BEATS = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [WIDTH-1:0]               in_a,
  input  logic [WIDTH-1:0]               in_b,
  input  logic [2:0]                     in_modo,
  input  logic                           in_last,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [2*WIDTH-1:0]             saida,
  output logic [$clog2(MAX_BEATS+1)-1:0] saida_beats,
  output logic                           saida_erro
);
  localparam int bw = $clog2(MAX_BEATS+1);
  localparam logic [bw-1:0] max_c = bw'(MAX_BEATS);
  estado_t estado, estado_nx;
  logic [WIDTH-1:0] acc, acc_nx, acc_or;
  logic [bw-1:0] cnt, cnt_nx, cnt_inc, beats_nx;
  logic [2*WIDTH-1:0] nuc_res, saida_nx;
  logic nuc_erro, erro_nx, aceita, fim, inicia;
  operar_vetores_nucleo #(.WIDTH(WIDTH)) u_nucleo (
    .a    (in_a),
    .b    (in_b),
    .modo (in_modo),
    .res  (nuc_res),
    .erro (nuc_erro)
  );
  assign out_valid = estado == SAIDA;
  assign in_ready  = !out_valid || out_ready;
  assign aceita    = in_valid && in_ready;
  // next state, accumulator and output-register load; outputs hold unless a result loads
  always_comb begin
    acc_or    = acc | in_a | in_b;
    cnt_inc   = cnt + bw'(1);
    fim       = in_last || cnt_inc == max_c;
    inicia    = in_modo == MODO_ACC_OR && !in_last;
    estado_nx = estado;
    acc_nx    = acc;
    cnt_nx    = cnt;
    saida_nx  = saida;
    beats_nx  = saida_beats;
    erro_nx   = saida_erro;
    if (estado == ACUMULANDO) begin
      if (aceita) begin
        acc_nx = fim ? '0 : acc_or;
        cnt_nx = fim ? '0 : cnt_inc;
        if (fim) begin
          saida_nx  = {{WIDTH{1'b0}}, acc_or};
          beats_nx  = cnt_inc;
          erro_nx   = !in_last;
          estado_nx = SAIDA;
        end
      end
    end else if (aceita) begin
      if (inicia) begin
        acc_nx    = in_a | in_b;
        cnt_nx    = bw'(1);
        estado_nx = ACUMULANDO;
      end else begin
        saida_nx  = nuc_res;
        beats_nx  = bw'(1);
        erro_nx   = nuc_erro;
        estado_nx = SAIDA;
      end
    end else if (estado == SAIDA && out_ready) begin
      estado_nx = OCIOSO;
    end
  end
  // state, accumulator and result registers; reset discards any partial burst
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado      <= OCIOSO;
      acc         <= '0;
      cnt         <= '0;
      saida       <= '0;
      saida_beats <= '0;
      saida_erro  <= 1'b0;
    end else begin
      estado      <= estado_nx;
      acc         <= acc_nx;
      cnt         <= cnt_nx;
      saida       <= saida_nx;
      saida_beats <= beats_nx;
      saida_erro  <= erro_nx;
    end
  end
endmodule

// File: tb/tb_operar_vetores_param.sv
// tb_operar_vetores_param: directed table and sequence checks for operar_vetores_param
module tb_operar_vetores_param;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic v3 = 0, r3 = 1, l3 = 1, ir3, ov3, e3;
  logic [2:0] m3 = 0, a3 = 0, b3 = 0;
  logic [5:0] s3;
  logic [4:0] bt3;
  logic v8 = 0, r8 = 1, l8 = 1, ir8, ov8, e8;
  logic [2:0] m8 = 0;
  logic [7:0] a8 = 0, b8 = 0;
  logic [15:0] s8;
  logic [2:0] bt8;
  int n_vec = 0;
  int n_err = 0;
  typedef struct {
    logic [2:0] modo;
    logic [2:0] a;
    logic [2:0] b;
    logic [5:0] s;
    logic       e;
  } vec_t;
  vec_t tab[12];
  always #5 clk = ~clk;
  operar_vetores_param #(.WIDTH(3), .MAX_BEATS(16)) u3 (
    .clk(clk), .rst_n(rst_n), .in_valid(v3), .in_ready(ir3), .in_a(a3), .in_b(b3),
    .in_modo(m3), .in_last(l3), .out_valid(ov3), .out_ready(r3), .saida(s3),
    .saida_beats(bt3), .saida_erro(e3)
  );
  operar_vetores_param #(.WIDTH(8), .MAX_BEATS(4)) u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(ir8), .in_a(a8), .in_b(b8),
    .in_modo(m8), .in_last(l8), .out_valid(ov8), .out_ready(r8), .saida(s8),
    .saida_beats(bt8), .saida_erro(e8)
  );
  task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask
  initial begin
    tab[0]  = '{3'd0, 3'b101, 3'b010, 6'b000111, 1'b0};
    tab[1]  = '{3'd1, 3'b101, 3'b011, 6'b000001, 1'b0};
    tab[2]  = '{3'd2, 3'b101, 3'b011, 6'b000110, 1'b0};
    tab[3]  = '{3'd3, 3'b101, 3'b010, 6'b101010, 1'b0};
    tab[4]  = '{3'd4, 3'b000, 3'b000, 6'b000000, 1'b0};
    tab[5]  = '{3'd4, 3'b000, 3'b100, 6'b000001, 1'b0};
    tab[6]  = '{3'd5, 3'b001, 3'b100, 6'b000101, 1'b0};
    tab[7]  = '{3'd6, 3'b111, 3'b111, 6'b000000, 1'b1};
    tab[8]  = '{3'd7, 3'b010, 3'b001, 6'b000000, 1'b1};
    tab[9]  = '{3'd3, 3'b111, 3'b111, 6'b000000, 1'b0};
    tab[10] = '{3'd3, 3'b000, 3'b000, 6'b111111, 1'b0};
    tab[11] = '{3'd2, 3'b110, 3'b110, 6'b000000, 1'b0};
    #1;
    chk("rst ov3", 16'(ov3), 16'd0);
    chk("rst s3", 16'(s3), 16'd0);
    chk("rst bt3", 16'(bt3), 16'd0);
    chk("rst e3", 16'(e3), 16'd0);
    chk("rst ov8", 16'(ov8), 16'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      v3 = 1; m3 = tab[i].modo; a3 = tab[i].a; b3 = tab[i].b; l3 = 1; r3 = 1;
      chk($sformatf("v%0d ir", i), 16'(ir3), 16'd1);
      @(negedge clk);
      v3 = 0;
      chk($sformatf("v%0d ov", i), 16'(ov3), 16'd1);
      chk($sformatf("v%0d s", i), 16'(s3), 16'(tab[i].s));
      chk($sformatf("v%0d bt", i), 16'(bt3), 16'd1);
      chk($sformatf("v%0d e", i), 16'(e3), 16'(tab[i].e));
    end
    @(negedge clk);
    v8 = 1; m8 = 3'd5; l8 = 0; a8 = 8'h01; b8 = 8'h00; r8 = 1;
    @(negedge clk);
    chk("acc ov b1", 16'(ov8), 16'd0);
    chk("acc ir b1", 16'(ir8), 16'd1);
    m8 = 3'd0; a8 = 8'h00; b8 = 8'h10;
    @(negedge clk);
    chk("acc ov b2", 16'(ov8), 16'd0);
    m8 = 3'd2; a8 = 8'h80; b8 = 8'h00; l8 = 1;
    @(negedge clk);
    v8 = 0;
    chk("acc ov", 16'(ov8), 16'd1);
    chk("acc s", s8, 16'h0091);
    chk("acc bt", 16'(bt8), 16'd3);
    chk("acc e", 16'(e8), 16'd0);
    @(negedge clk);
    chk("acc done ov", 16'(ov8), 16'd0);
    for (int i = 0; i < 4; i++) begin
      v8 = 1; m8 = 3'd5; l8 = 0; a8 = 8'(1 << i); b8 = 8'h00;
      @(negedge clk);
      if (i < 3) chk($sformatf("ovf ov b%0d", i + 1), 16'(ov8), 16'd0);
    end
    chk("ovf ov", 16'(ov8), 16'd1);
    chk("ovf s", s8, 16'h000f);
    chk("ovf bt", 16'(bt8), 16'd4);
    chk("ovf e", 16'(e8), 16'd1);
    a8 = 8'h20;
    @(negedge clk);
    chk("ovf b5 ov", 16'(ov8), 16'd0);
    a8 = 8'h40; l8 = 1;
    @(negedge clk);
    v8 = 0;
    chk("new burst s", s8, 16'h0060);
    chk("new burst bt", 16'(bt8), 16'd2);
    chk("new burst e", 16'(e8), 16'd0);
    @(negedge clk);
    r8 = 0; v8 = 1; m8 = 3'd0; a8 = 8'h11; b8 = 8'h22; l8 = 1;
    @(negedge clk);
    a8 = 8'h44; b8 = 8'h00;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp ir %0d", k), 16'(ir8), 16'd0);
      chk($sformatf("bp s %0d", k), s8, 16'h0033);
      chk($sformatf("bp ov %0d", k), 16'(ov8), 16'd1);
      @(negedge clk);
    end
    r8 = 1;
    #1;
    chk("bp release ir", 16'(ir8), 16'd1);
    @(negedge clk);
    chk("b2b s1", s8, 16'h0044);
    chk("b2b ov1", 16'(ov8), 16'd1);
    a8 = 8'h55;
    @(negedge clk);
    chk("b2b s2", s8, 16'h0055);
    chk("b2b ov2", 16'(ov8), 16'd1);
    v8 = 0;
    @(negedge clk);
    chk("b2b drain ov", 16'(ov8), 16'd0);
    v8 = 1; m8 = 3'd5; l8 = 0; a8 = 8'hff; b8 = 8'h00;
    @(negedge clk);
    @(negedge clk);
    v8 = 0;
    rst_n = 0;
    #1;
    chk("mid rst ov", 16'(ov8), 16'd0);
    chk("mid rst s", s8, 16'h0000);
    chk("mid rst bt", 16'(bt8), 16'd0);
    chk("mid rst e", 16'(e8), 16'd0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("post rst ov", 16'(ov8), 16'd0);
    v8 = 1; m8 = 3'd5; l8 = 1; a8 = 8'h02; b8 = 8'h00;
    @(negedge clk);
    v8 = 0;
    chk("post rst s", s8, 16'h0002);
    chk("post rst bt", 16'(bt8), 16'd1);
    chk("post rst ov1", 16'(ov8), 16'd1);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/operar_vetores_param.md
# operar_vetores_param

Parametrised, registered vector-operation unit. It takes two `WIDTH`-bit operand vectors per beat over a valid/ready handshake and applies a selectable operation: bitwise OR/AND/XOR, concatenated inversion, logical OR, or a multi-beat OR accumulation. Each result is returned through a registered output with its own valid/ready handshake. It sits between operand producers and result consumers in the vector datapath, replacing the fixed 3-bit combinational operator.

## Interface
- `WIDTH`, 8: operand width in bits (≥1)
- `MAX_BEATS`, 16: beat limit for accumulation mode (≥2)
- `clk` input 1: clock, rising edge
- `rst_n` input 1: asynchronous, active-low reset
- `in_valid` input 1: operand beat valid
- `in_ready` output 1: unit accepts a beat this cycle
- `in_a` input WIDTH: operand a
- `in_b` input WIDTH: operand b
- `in_modo` input 3: operation select
- `in_last` input 1: final beat of an accumulation burst
- `out_valid` output 1: result valid
- `out_ready` input 1: consumer accepts the result
- `saida` output 2*WIDTH: result, zero-extended
- `saida_beats` output $clog2(MAX_BEATS+1): number of beats folded into the result
- `saida_erro` output 1: reserved mode or accumulation overflow

## Operation
- Handshakes:
  - A beat transfers when `in_valid && in_ready`.
  - A result transfers when `out_valid && out_ready`.
  - `in_ready = !out_valid || out_ready`, the combinational single-register pass-through.
- Modes (`in_modo`):
  - 0 OR: `saida = {0, a|b}`
  - 1 AND: `{0, a&b}`
  - 2 XOR: `{0, a^b}`
  - 3 NOT: `{~b, ~a}`
  - 4 OR_LOGICO: bit0 = `(|a)|(|b)`, the rest 0
  - 5 ACC_OR: OR of `a|b` across the beats of a burst, placed in the low WIDTH bits
  - 6, 7 reserved: `saida = 0`, `saida_erro = 1`
- Modes 0–4 and 6–7 produce one result per accepted beat, with `saida_beats = 1`.
- FSM states are `OCIOSO`, `ACUMULANDO` and `SAIDA`.
- From `OCIOSO`:
  - An accepted non-ACC beat loads the output register and moves to `SAIDA`.
  - An accepted ACC beat with `in_last = 1` behaves as a single-beat ACC: result `a|b`, beats = 1, then `SAIDA`.
  - An accepted ACC beat with `in_last = 0` loads the accumulator, sets count = 1 and moves to `ACUMULANDO`.
- In `ACUMULANDO`:
  - `out_valid = 0`, so `in_ready = 1`.
  - `in_modo` is ignored; the mode is latched at the first beat.
  - Each accepted beat ORs into the accumulator and increments the count.
  - On `in_last`, or when count reaches `MAX_BEATS`, the result is emitted and the FSM moves to `SAIDA`.
  - If the count reaches `MAX_BEATS` without `in_last`, the result is emitted with `saida_erro = 1`. The next beat starts a new burst.
- In `SAIDA`:
  - `out_valid = 1`.
  - If `out_ready` is high and an input beat arrives in the same cycle, the next result loads back-to-back. The FSM stays in `SAIDA`, or goes to `ACUMULANDO` if the new beat is a non-last ACC beat.
  - If `out_ready` is high with no input beat, the FSM returns to `OCIOSO`.
- While `out_valid = 1 && out_ready = 0`, `saida`, `saida_beats` and `saida_erro` are held stable.

## Timing
- Reset (async assert, sync release): FSM = `OCIOSO`, `out_valid = 0`, `saida = 0`, `saida_beats = 0`, `saida_erro = 0`, accumulator = 0, count = 0.
- Latency:
  - Single-beat modes: result valid one cycle after acceptance.
  - ACC: result valid one cycle after the last beat is accepted.
- Throughput is one result per cycle when `out_ready` is held high.
- If reset asserts mid-burst, the partial accumulation is discarded and no result is emitted.
- `in_ready` depends combinationally on `out_ready`. No other input-to-output combinational paths are permitted.

## Structure
- `operar_vetores_pkg` holds:
  - the `modo_t` enum (`MODO_OR`, `MODO_AND`, `MODO_XOR`, `MODO_NOT`, `MODO_OR_LOGICO`, `MODO_ACC_OR`)
  - the `estado_t` enum
  - a `modo_valido()` function
- One combinational sub-module, `operar_vetores_nucleo` (params `WIDTH`), maps `a`, `b`, `modo` to the 2*WIDTH result and an error flag. The top level holds the FSM, accumulator, counter and handshakes.

## Test plan
- WIDTH=3, modo=0, a=3'b101, b=3'b010 → next cycle `out_valid = 1`, `saida = 6'b000111`, beats = 1, erro = 0.
- WIDTH=3, modo=3, a=3'b101, b=3'b010 → `saida = 6'b101010`. Modo=4 with a=b=0 → `saida = 0`. Modo=4 with a=0, b=3'b100 → `saida = 6'b000001`.
- WIDTH=8, ACC burst of 3 beats with a/b = 01/00, 00/10, 80/00 and last on beat 3 → one result: `saida[7:0] = 8'h91`, beats = 3, erro = 0. `out_valid` stays 0 during the burst.
- MAX_BEATS=4, ACC burst with `in_last` never set → result after beat 4 with beats = 4, erro = 1. Beat 5 starts a new burst.
- Hold `out_ready = 0` for 5 cycles with `in_valid = 1` → `in_ready = 0`, output stable and no beat lost. Releasing `out_ready` with `in_valid` high gives back-to-back results, one per cycle.
- Modo = 6 → `saida = 0`, erro = 1. Assert `rst_n = 0` mid-ACC after 2 beats → all outputs 0 immediately, and no stale result after release.
